// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM in, word-organised data memory, registered MEM/WB bundle out.
// Optional byte-lane access enabled by defining MEM_STAGE_BYTE_EN.

package mem_stage_pkg;

  // Captured EX/MEM instruction
  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ex_mem_t;

  // MEM/WB bundle handed to write-back
  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] address;
    logic [31:0] read_data;
    logic        misaligned;
  } mem_wb_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_mem_byte,
  input  logic        in_mem_to_reg,
  input  logic        in_reg_write,
  input  logic [4:0]  in_write_back_destination,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_write_data,
  output logic        stall,
  output logic        out_valid,
  output logic        out_mem_to_reg,
  output logic        out_reg_write,
  output logic [4:0]  out_write_back_destination,
  output logic [31:0] out_address,
  output logic [31:0] out_read_data,
  output logic        out_misaligned
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam bit          MULTI    = (MEM_LATENCY > 1);
  localparam int unsigned CNT_LOAD = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  ex_mem_t        hold_q, hold_d;
  mem_wb_t        wb_q, wb_d;
  logic           valid_q, valid_d;
  logic           stall_q;

  ex_mem_t        in_bus;
  ex_mem_t        cur;
  logic [AW-1:0]  idx;
  logic [1:0]     lane;
  logic [4:0]     lane_sh;
  logic           mem_op;
  logic           is_byte;
  logic           misaligned;
  logic [31:0]    rword;
  logic [7:0]     rbyte;
  logic [31:0]    lane_mask;
  logic [31:0]    rdata;
  logic [31:0]    wword;
  logic           do_access;
  logic           we;

  logic [31:0]    mem [DEPTH_WORDS];

  // Pack the live inputs; ACCESS works only from the captured copy
  always_comb begin
    in_bus            = '0;
    in_bus.mem_read   = in_mem_read;
    in_bus.mem_write  = in_mem_write;
    in_bus.mem_byte   = in_mem_byte;
    in_bus.mem_to_reg = in_mem_to_reg;
    in_bus.reg_write  = in_reg_write;
    in_bus.dest       = in_write_back_destination;
    in_bus.addr       = in_alu_result;
    in_bus.wdata      = in_write_data;
    cur               = (state_q == ACCESS) ? hold_q : in_bus;
  end

`ifdef MEM_STAGE_BYTE_EN
  assign is_byte = cur.mem_byte;
`else
  logic unused_mem_byte;
  assign is_byte         = 1'b0;
  assign unused_mem_byte = cur.mem_byte;
`endif

  // Address decode, read path and store-word merge
  always_comb begin
    idx        = cur.addr[AW+1:2];
    lane       = cur.addr[1:0];
    lane_sh    = {lane, 3'b000};
    mem_op     = cur.mem_read | cur.mem_write;
    misaligned = mem_op && !is_byte && (lane != 2'b00);
    rword      = mem[idx];
    rbyte      = 8'(rword >> lane_sh);
    lane_mask  = 32'h0000_00FF << lane_sh;
    rdata      = '0;
    if (cur.mem_read && !misaligned) begin
      rdata = is_byte ? 32'(rbyte) : rword;
    end
    wword = cur.wdata;
    if (is_byte) begin
      wword = (rword & ~lane_mask) | (32'(cur.wdata[7:0]) << lane_sh);
    end
  end

  // Next-state, counter and bundle logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    wb_d      = wb_q;
    valid_d   = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_op && MULTI) begin
            hold_d  = in_bus;
            cnt_d   = CW'(CNT_LOAD);
            state_d = ACCESS;
          end else begin
            do_access = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          do_access = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      wb_d.mem_to_reg = cur.mem_to_reg;
      wb_d.reg_write  = cur.reg_write;
      wb_d.dest       = cur.dest;
      wb_d.address    = cur.addr;
      wb_d.read_data  = rdata;
      wb_d.misaligned = misaligned;
      valid_d         = 1'b1;
    end
  end

  assign we = do_access && cur.mem_write && !misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      wb_q    <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
      valid_q <= valid_d;
      stall_q <= (state_d == ACCESS);
    end
  end

  // Data array keeps its contents through reset; reset aborts a pending store
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[idx] <= wword;
    end
  end

  assign stall                      = stall_q;
  assign out_valid                  = valid_q;
  assign out_mem_to_reg             = wb_q.mem_to_reg;
  assign out_reg_write              = wb_q.reg_write;
  assign out_write_back_destination = wb_q.dest;
  assign out_address                = wb_q.address;
  assign out_read_data              = wb_q.read_data;
  assign out_misaligned             = wb_q.misaligned;

endmodule
